// File: rtl/aes_pkg.sv
// Shared AES definitions for the reverse key schedule.
// Contents: word/key typedefs, FSM state enum, default rcon for undoing
// round 10, RotWord and inverse-xtime helpers.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Forward rcon of round 10; the first inverse step must undo it.
    localparam logic [7:0] RCON_LAST = 8'h36;

    // RotWord: cyclic left rotation by one byte.
    function automatic word_t rot_word(input word_t x);
        return {x[23:0], x[31:24]};
    endfunction

    // Division by x in GF(2^8): reverses the forward rcon doubling.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        logic [7:0] res;
        if (r[0]) begin
            res = (r >> 1) ^ 8'h8d;
        end else begin
            res = r >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sbox.sv
// Four parallel AES S-boxes on a 32-bit word (SubWord), purely combinational.
// Each byte is computed as the GF(2^8) multiplicative inverse followed by the
// AES affine transform, so no lookup table has to be maintained.
// Ports:
//   word  in  32  input word
//   sub   out 32  SubWord(word)
module sbox
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ 8'h1b;
            end else begin
                aa = {aa[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    // Inverse as x^254 (254 = 2+4+...+128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] s;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Byte-wise substitution of the whole word.
    always_comb begin
        sub = {sbox_byte(word[31:24]), sbox_byte(word[23:16]),
               sbox_byte(word[15:8]),  sbox_byte(word[7:0])};
    end

endmodule

// File: rtl/inv_key_expansion128.sv
// Reverse AES-128 key schedule: takes the last round key and streams round
// keys NR, NR-1 .. 0 through a valid/ready output, one per accepted beat.
// Optional macro INV_KEY_BUFFER_EN adds a register file of all emitted keys
// with a combinational read port (rd_idx/rd_key).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     start handshake, in_key = round-NR key
//   out_valid/out_ready   output handshake, out_key of round out_round
//   rd_idx/rd_key         buffer read port (INV_KEY_BUFFER_EN only)
//   done                  one-cycle pulse after the round-0 key is accepted
module inv_key_expansion128
    import aes_pkg::*;
#(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_LAST = aes_pkg::RCON_LAST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
`ifdef INV_KEY_BUFFER_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
`endif
    output logic         done
);

    state_t     state_r, state_s;
    key_t       cur_key_r, cur_key_s;
    logic [7:0] rcon_r, rcon_s;
    logic [3:0] round_r, round_s;
    logic       done_r, done_s;
    logic       out_valid_r;
    logic       in_ready_r;

    word_t a_p_s, b_p_s, c_p_s, d_p_s;
    word_t a_n_s, b_n_s, c_n_s, d_n_s;
    word_t rot_s, sub_s;
    logic  beat_s;

    // Split the current key into words and undo one forward schedule step.
    always_comb begin
        {a_p_s, b_p_s, c_p_s, d_p_s} = cur_key_r;
        d_n_s = d_p_s ^ c_p_s;
        c_n_s = c_p_s ^ b_p_s;
        b_n_s = b_p_s ^ a_p_s;
        rot_s = rot_word(d_n_s);
        a_n_s = a_p_s ^ sub_s ^ {rcon_r, 24'h000000};
    end

    sbox u_sbox (
        .word (rot_s),
        .sub  (sub_s)
    );

    assign beat_s = (state_r == EMIT) && out_ready;

    // Next-state and datapath update.
    always_comb begin
        state_s   = state_r;
        cur_key_s = cur_key_r;
        rcon_s    = rcon_r;
        round_s   = round_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    cur_key_s = in_key;
                    rcon_s    = RCON_LAST;
                    round_s   = 4'(NR);
                    state_s   = EMIT;
                end else begin
                    state_s = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (round_r == 4'd0) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        cur_key_s = {a_n_s, b_n_s, c_n_s, d_n_s};
                        rcon_s    = inv_xtime(rcon_r);
                        round_s   = round_r - 4'd1;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_key_r   <= 128'h0;
            rcon_r      <= 8'h00;
            round_r     <= 4'd0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            cur_key_r   <= cur_key_s;
            rcon_r      <= rcon_s;
            round_r     <= round_s;
            done_r      <= done_s;
            out_valid_r <= (state_s == EMIT);
            in_ready_r  <= (state_s == IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_key   = cur_key_r;
    assign out_round = round_r;
    assign done      = done_r;

`ifdef INV_KEY_BUFFER_EN
    key_t key_buf_r [0:NR];

    // Capture every accepted beat at its round index; survives across walks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) begin
                key_buf_r[i] <= 128'h0;
            end
        end else if (beat_s) begin
            key_buf_r[round_r] <= cur_key_r;
        end else begin
            key_buf_r[round_r] <= key_buf_r[round_r];
        end
    end

    // Combinational read; indices beyond NR read as zero.
    always_comb begin
        if (rd_idx <= 4'(NR)) begin
            rd_key = key_buf_r[rd_idx];
        end else begin
            rd_key = 128'h0;
        end
    end
`else
    logic unused_beat_s;
    assign unused_beat_s = beat_s;
`endif

endmodule

// File: tb/tb_inv_key_expansion128.sv
module tb_inv_key_expansion128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         done;
`ifdef INV_KEY_BUFFER_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    always #5 clk = ~clk;

    inv_key_expansion128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
`ifdef INV_KEY_BUFFER_EN
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
`endif
        .done      (done)
    );

    // FIPS-197 A.1 schedule of key 2b7e1516..., round 0..10.
    logic [127:0] ka [0:10];
    // FIPS-197 C.1 (key 000102..0f): known round 10, 9 and 0 keys.
    logic [127:0] kc10, kc9, kc0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    bit exp_done = 1'b0;
    bit held_v = 1'b0;
    logic [127:0] held_key;
    logic [3:0]   held_round;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_walk(input logic [127:0] k);
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            if (k === ka[10]) begin
                e.key = ka[r];
                e.chk_key = 1'b1;
            end else begin
                e.key = (r == 10) ? kc10 : (r == 9) ? kc9 : kc0;
                e.chk_key = (r == 10) || (r == 9) || (r == 0);
            end
            sb.push_back(e);
        end
    endtask

    // One clock cycle; called right after a falling edge.
    task automatic cyc(input bit rdy);
        exp_t e;
        out_ready = rdy;
        chk("done", {127'h0, done}, {127'h0, exp_done});
        exp_done = 1'b0;
        if (held_v) begin
            chk("stall_valid", {127'h0, out_valid}, 128'h1);
            chk("stall_key", out_key, held_key);
            chk("stall_round", {124'h0, out_round}, {124'h0, held_round});
        end
        held_v = 1'b0;
        if (in_valid && in_ready) push_walk(in_key);
        if (out_valid) begin
            chk("in_ready_busy", {127'h0, in_ready}, 128'h0);
            if (rdy) begin
                chk("sb_nonempty", {127'h0, sb.size() != 0}, 128'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("round", {124'h0, out_round}, {124'h0, e.rnd});
                    if (e.chk_key) chk($sformatf("key_r%0d", e.rnd), out_key, e.key);
                    if (e.rnd == 4'd0) exp_done = 1'b1;
                end
            end else begin
                held_v     = 1'b1;
                held_key   = out_key;
                held_round = out_round;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input bit rnd_bp);
        bit finished = 1'b0;
        for (int i = 0; i < 400 && !finished; i++) begin
            cyc(rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1);
            if (sb.size() == 0 && exp_done) finished = 1'b1;
        end
        chk("drain_complete", {127'h0, finished}, 128'h1);
    endtask

    initial begin
        ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        kc10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        kc9    = 128'h549932d1f08557681093ed9cbe2c974e;
        kc0    = 128'h000102030405060708090a0b0c0d0e0f;

        rst_n = 1'b0; in_valid = 1'b0; in_key = 128'h0; out_ready = 1'b0;
`ifdef INV_KEY_BUFFER_EN
        rd_idx = 4'd0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_done", {127'h0, done}, 128'h0);
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_out_key", out_key, 128'h0);
        chk("rst_out_round", {124'h0, out_round}, 128'h0);

        // FIPS-197 A.1 walk, no backpressure.
        in_valid = 1'b1; in_key = ka[10];
        cyc(1'b1);
        in_valid = 1'b0;
        chk("latency_a", {127'h0, out_valid}, 128'h1);
        drain(1'b0);

`ifdef INV_KEY_BUFFER_EN
        rd_idx = 4'd0;  #1 chk("buf_idx0", rd_key, ka[0]);
        rd_idx = 4'd10; #1 chk("buf_idx10", rd_key, ka[10]);
        rd_idx = 4'd11; #1 chk("buf_idx11", rd_key, 128'h0);
        rd_idx = 4'd5;  #1 chk("buf_idx5", rd_key, ka[5]);
`endif

        // Back-to-back: C.1 key offered in the done cycle.
        in_valid = 1'b1; in_key = kc10;
        cyc(1'b1);
        chk("latency_b2b", {127'h0, out_valid}, 128'h1);
        // Different key held valid during the walk must be ignored.
        in_key = ka[10];
        drain(1'b1);
        // Accepted only once the engine is idle again (done cycle).
        cyc(1'b1);
        in_valid = 1'b0;
        chk("accept_after_done", {127'h0, out_valid}, 128'h1);

        // Abort with reset while round 5 is on the output.
        for (int i = 0; i < 20 && !(out_valid && out_round == 4'd5); i++) cyc(1'b1);
        chk("reached_round5", {124'h0, out_round}, 128'h5);
        rst_n = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        held_v = 1'b0;
        exp_done = 1'b0;
        chk("abort_out_valid", {127'h0, out_valid}, 128'h0);
        chk("abort_in_ready", {127'h0, in_ready}, 128'h1);
        chk("abort_out_round", {124'h0, out_round}, 128'h0);
        repeat (4) cyc(1'b1);

        // Fresh C.1 walk with random backpressure.
        in_valid = 1'b1; in_key = kc10;
        cyc(1'b0);
        in_valid = 1'b0;
        drain(1'b1);
        cyc(1'b1);
        chk("sb_empty", 128'(sb.size()), 128'h0);
        chk("idle_in_ready", {127'h0, in_ready}, 128'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
